// File: rtl/elevador.sv
// Elevator floor controller: one-step-per-cycle up/down motion with registered
// motor drives and a seven-segment decode of the current floor.
module elevador #(
  parameter int NUM_FLOORS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] boton,
  input  logic [3:0] dato,
  output logic       motorsubir,
  output logic       motorbajar,
  output logic [6:0] display
);

  localparam logic [3:0] TOP_FLOOR = 4'(NUM_FLOORS);

  logic [3:0] piso_r;
  logic [3:0] piso_s;
  logic       subir_s;
  logic       bajar_s;
  logic       unused_dato_s;

  // Reserved control bits are deliberately not consumed by any logic.
  assign unused_dato_s = ^dato[3:1];

  function automatic logic [6:0] seg_decode(input logic [3:0] floor);
    logic [6:0] seg;
    case (floor)
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

  // Next floor and motor request; a step is only taken away from the boundary.
  always_comb begin
    piso_s  = piso_r;
    subir_s = 1'b0;
    bajar_s = 1'b0;
    if (dato[0]) begin
      case (boton)
        2'b10: begin
          if (piso_r < TOP_FLOOR) begin
            piso_s  = piso_r + 4'd1;
            subir_s = 1'b1;
          end else begin
            piso_s  = piso_r;
          end
        end
        2'b01: begin
          if (piso_r > 4'd1) begin
            piso_s  = piso_r - 4'd1;
            bajar_s = 1'b1;
          end else begin
            piso_s  = piso_r;
          end
        end
        default: begin
          piso_s = piso_r;
        end
      endcase
    end else begin
      piso_s = piso_r;
    end
  end

  // Floor and motor drives update together so the pulse marks the step.
  always_ff @(posedge clk) begin
    if (reset) begin
      piso_r     <= 4'd1;
      motorsubir <= 1'b0;
      motorbajar <= 1'b0;
    end else begin
      piso_r     <= piso_s;
      motorsubir <= subir_s;
      motorbajar <= bajar_s;
    end
  end

  // Display follows the floor register directly.
  always_comb begin
    display = seg_decode(piso_r);
  end

endmodule

// File: tb/tb_elevador.sv
// Directed vector bench for elevador (NUM_FLOORS = 4): table of per-cycle
// stimulus/expectations plus hand-written reset and held-command sequences.
module tb_elevador;

  localparam logic [6:0] D1 = 7'b0000110;
  localparam logic [6:0] D2 = 7'b1011011;
  localparam logic [6:0] D3 = 7'b1001111;
  localparam logic [6:0] D4 = 7'b1100110;

  typedef struct {
    logic       rst;
    logic [1:0] boton;
    logic [3:0] dato;
    logic       up;
    logic       dn;
    logic [6:0] disp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] boton;
  logic [3:0] dato;
  logic       motorsubir;
  logic       motorbajar;
  logic [6:0] display;

  int tests_run;
  int tests_failed;

  elevador #(.NUM_FLOORS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .boton      (boton),
    .dato       (dato),
    .motorsubir (motorsubir),
    .motorbajar (motorbajar),
    .display    (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [1:0] b, input logic [3:0] d,
                              input logic u, input logic n, input logic [6:0] s);
    vec_t v;
    v.rst = r; v.boton = b; v.dato = d; v.up = u; v.dn = n; v.disp = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, clock it, then compare outputs and invariants.
  task automatic apply(input string tag, input vec_t v);
    logic legal;
    @(negedge clk);
    reset = v.rst;
    boton = v.boton;
    dato  = v.dato;
    @(posedge clk);
    #1;
    check({tag, " motorsubir"}, {6'd0, motorsubir}, {6'd0, v.up});
    check({tag, " motorbajar"}, {6'd0, motorbajar}, {6'd0, v.dn});
    check({tag, " display"}, display, v.disp);
    check({tag, " motors exclusive"}, {6'd0, motorsubir & motorbajar}, 7'd0);
    legal = (display === D1) || (display === D2) || (display === D3) || (display === D4);
    check({tag, " floor in range"}, {6'd0, legal}, 7'd1);
  endtask

  vec_t vecs [0:23];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    boton = 2'b00;
    dato  = 4'b0000;

    vecs[0]  = mk(1'b1, 2'b00, 4'b0001, 1'b0, 1'b0, D1);
    vecs[1]  = mk(1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, D1);
    vecs[2]  = mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D2);
    vecs[3]  = mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D3);
    vecs[4]  = mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b1, D2);
    vecs[5]  = mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b1, D1);
    vecs[6]  = mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b0, D1);
    vecs[7]  = mk(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, D1);
    vecs[8]  = mk(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, D1);
    vecs[9]  = mk(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, D1);
    vecs[10] = mk(1'b0, 2'b11, 4'b0001, 1'b0, 1'b0, D1);
    vecs[11] = mk(1'b0, 2'b10, 4'b1110, 1'b0, 1'b0, D1);
    vecs[12] = mk(1'b0, 2'b10, 4'b1111, 1'b1, 1'b0, D2);
    vecs[13] = mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D3);
    vecs[14] = mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D4);
    vecs[15] = mk(1'b0, 2'b10, 4'b0001, 1'b0, 1'b0, D4);
    vecs[16] = mk(1'b0, 2'b10, 4'b0001, 1'b0, 1'b0, D4);
    vecs[17] = mk(1'b0, 2'b11, 4'b0001, 1'b0, 1'b0, D4);
    vecs[18] = mk(1'b0, 2'b01, 4'b1110, 1'b0, 1'b0, D4);
    vecs[19] = mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b1, D3);
    vecs[20] = mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, D1);
    vecs[21] = mk(1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, D1);
    vecs[22] = mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D2);
    vecs[23] = mk(1'b0, 2'b10, 4'b0000, 1'b0, 1'b0, D2);

    for (int i = 0; i < 24; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Held up-command from floor 1: steps each cycle, stops at the top.
    apply("seq1 rst", mk(1'b1, 2'b00, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq1 up1", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D2));
    apply("seq1 up2", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D3));
    apply("seq1 up3", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D4));
    apply("seq1 top", mk(1'b0, 2'b10, 4'b0001, 1'b0, 1'b0, D4));

    // Reset mid-travel with down held, then no motion resumes without a command.
    apply("seq2 dn", mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b1, D3));
    apply("seq2 rst", mk(1'b1, 2'b01, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq2 idle1", mk(1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq2 idle2", mk(1'b0, 2'b00, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq2 dn floor1", mk(1'b0, 2'b01, 4'b0001, 1'b0, 1'b0, D1));

    // Reset held for two cycles against an up command at floor 3.
    apply("seq3 up1", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D2));
    apply("seq3 up2", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D3));
    apply("seq3 rst1", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq3 rst2", mk(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, D1));
    apply("seq3 resume", mk(1'b0, 2'b10, 4'b0001, 1'b1, 1'b0, D2));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
